irq_priority_controller: RTL
============================

# irq_priority_controller

Prioritised interrupt controller that sequences the processor's PC redirect and pipeline flush on interrupt entry and return. Latches edge-triggered requests into pending bits, applies a software-written mask, and issues one redirect request at a time to the fetch/PC logic over a req/ack handshake. It saves the interrupted PC and, on return, replays it through the same handshake. It sits beside the PC/IF stage and replaces direct use of the raw `interrupt` pin.

## Interface
- `NUM_IRQ`, 4, number of interrupt lines; index 0 is the highest priority.
- `VECTOR_BASE`, 32'h0000_1000, vector address of line 0.
- `VECTOR_STRIDE`, 32'h0000_0010, address spacing between consecutive line vectors.

Ports:
- `clk` in 1: single clock; all state updates on posedge.
- `reset` in 1: synchronous, active-high.
- `irq_in` in NUM_IRQ: raw request lines; a rising edge raises a request.
- `mask_we` in 1: write strobe for the enable mask.
- `mask_wdata` in NUM_IRQ: new mask value; 1 = line enabled.
- `epc_in` in 32: PC of the oldest unretired instruction; sampled on the entry handshake.
- `irq_return` in 1: one-cycle pulse marking return-from-interrupt retired.
- `redirect_req` out 1: request that the PC be loaded with `redirect_pc`.
- `redirect_pc` out 32: target PC; stable while `redirect_req` is high.
- `redirect_ack` in 1: the PC logic accepted the redirect this cycle.
- `flush` out 1: squash the IF/ID, ID/EX and EX/MEM registers.
- `busy` out 1: high in any state other than IDLE.
- `active_id` out $clog2(NUM_IRQ): line currently in service.
- `pending` out NUM_IRQ: latched, uncleared requests.
- `mask` out NUM_IRQ: current enable mask.

## Operation
- Edge detect:
  - `irq_q` holds `irq_in` from the previous cycle.
  - `edge = irq_in & ~irq_q`.
  - The pending bit sets on `edge` and clears on the entry ack of that line.
  - If set and clear coincide on the same line, set wins.
- Mask: written on `mask_we`. Selection in the same cycle uses the old mask. Masking never clears pending bits.
- Selection: `eligible = pending & mask`. The winner is the lowest set index. Evaluated only in IDLE.
- FSM states: IDLE, ENTER, SERVICE, RETURN.
  - IDLE: if `eligible` is non-zero, latch the winner into `active_id` and go to ENTER.
  - ENTER:
    - Drive `redirect_req` = 1, `flush` = 1, `redirect_pc = VECTOR_BASE + active_id*VECTOR_STRIDE`.
    - On `redirect_ack`: latch `epc_in` into `saved_epc`, clear `pending[active_id]`, go to SERVICE.
  - SERVICE:
    - Outputs idle.
    - There is no nesting; new edges only accumulate in pending.
    - On `irq_return`, go to RETURN.
  - RETURN:
    - Drive `redirect_req` = 1, `flush` = 1, `redirect_pc = saved_epc`.
    - On `redirect_ack`, go to IDLE.
- Address arithmetic: 32-bit unsigned, wraps modulo 2^32, no overflow flag.
- `irq_return` outside SERVICE is ignored.
- `redirect_ack` while `redirect_req` is low is ignored.
- Reset values: state IDLE; `pending`, `irq_q`, `active_id`, `saved_epc` = 0; `mask` = all ones; `redirect_req`, `flush`, `busy` = 0; `redirect_pc` = 0.
- Reset mid-operation (any state): return to the reset values next cycle. Requests in flight are lost and no redirect completes.

## Timing
- Entry latency: rising edge of `irq_in` sampled at posedge N.
  - `pending` is visible after N.
  - State is ENTER, with `redirect_req` high, after N+1.
  - With `redirect_ack` high in the first ENTER cycle, the state is SERVICE after N+2.
- `redirect_req`, `redirect_pc` and `flush` are registered-state decodes (Moore).
  - They stay constant until the ack cycle inclusive.
  - They deassert in the cycle after the ack.
- The ack handshake completes on the posedge where `redirect_req` and `redirect_ack` are both high.
- Return latency: after an `irq_return` pulse in SERVICE at posedge M, RETURN begins in the next cycle.
- Back-to-back: after RETURN completes, IDLE may select a new winner in its first cycle. The minimum IDLE dwell is 1 cycle.
- Gaps: `redirect_ack` may arrive any number of cycles after the request; no timeout.

## Structure
- Shared package `irq_pkg`:
  - typedef `irq_state_t` (IDLE, ENTER, SERVICE, RETURN).
  - Default constants `IRQ_VECTOR_BASE` and `IRQ_VECTOR_STRIDE`.
- One sub-module `irq_priority_encoder`: combinational lowest-index-first encoder producing `valid` and `id`.
- Edge detect, mask, FSM and EPC register live in the top module.

## Test plan
- `irq_in[2]` rises, mask all ones, ack on the first ENTER cycle -> `redirect_req` high 2 cycles after the edge, `redirect_pc` = 0x1020, `flush` high, `pending[2]` clears on ack, `active_id` = 2.
- `irq_in[1]` and `irq_in[3]` rise in the same cycle -> line 1 serviced first (pc 0x1010). After `irq_return` and return ack, line 3 is taken (pc 0x1030) with no further edge.
- `mask` = 4'b1110, `irq_in[0]` rises -> stays pending, no request. Write `mask` = 4'b1111 -> ENTER follows, pc 0x1000.
- `epc_in` = 0x0000_0044 at entry ack, ack delayed 5 cycles, then `irq_return` -> request held 5 cycles; return `redirect_pc` = 0x44.
- Edges:
  - `irq_return` pulse in IDLE -> no state change.
  - `irq_in[2]` re-rises during SERVICE of line 2 -> `pending[2]` = 1 after return.
- Reset asserted during ENTER with ack low -> next cycle state IDLE, `redirect_req` = 0, `pending` = 0, `mask` = 4'b1111.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared types and default vector constants for the interrupt priority controller.
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ENTER   = 2'd1,
    SERVICE = 2'd2,
    RETURN  = 2'd3
  } irq_state_t;

  localparam logic [31:0] IRQ_VECTOR_BASE   = 32'h0000_1000;
  localparam logic [31:0] IRQ_VECTOR_STRIDE = 32'h0000_0010;

endpackage

// File: rtl/irq_priority_encoder.sv
// Combinational priority encoder: lowest set index wins.
module irq_priority_encoder #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  output logic                 valid,
  output logic [$clog2(N)-1:0] id
);

  localparam int W = $clog2(N);

  always_comb begin
    valid = |req;
    id    = '0;
    // Scan high to low so the lowest set index is written last.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) id = W'(i);
    end
  end

endmodule

// File: rtl/irq_priority_controller.sv
// Interrupt controller that sequences PC redirect and pipeline flush on entry and return.
//   state   | meaning
//   IDLE    | waiting for an eligible pending line
//   ENTER   | redirect to the line's vector, flush, wait for ack
//   SERVICE | handler running, waiting for irq_return
//   RETURN  | redirect to the saved EPC, flush, wait for ack
module irq_priority_controller
  import irq_pkg::*;
#(
  parameter int          NUM_IRQ       = 4,
  parameter logic [31:0] VECTOR_BASE   = IRQ_VECTOR_BASE,
  parameter logic [31:0] VECTOR_STRIDE = IRQ_VECTOR_STRIDE
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_IRQ-1:0]         irq_in,
  input  logic                       mask_we,
  input  logic [NUM_IRQ-1:0]         mask_wdata,
  input  logic [31:0]                epc_in,
  input  logic                       irq_return,
  output logic                       redirect_req,
  output logic [31:0]                redirect_pc,
  input  logic                       redirect_ack,
  output logic                       flush,
  output logic                       busy,
  output logic [$clog2(NUM_IRQ)-1:0] active_id,
  output logic [NUM_IRQ-1:0]         pending,
  output logic [NUM_IRQ-1:0]         mask
);

  irq_state_t           state, state_nxt;
  logic [NUM_IRQ-1:0]   irq_q;
  logic [NUM_IRQ-1:0]   irq_edge;
  logic [NUM_IRQ-1:0]   pend_clr;
  logic [31:0]          saved_epc;
  logic                 enc_valid;
  logic [$clog2(NUM_IRQ)-1:0] enc_id;

  assign irq_edge = irq_in & ~irq_q;

  irq_priority_encoder #(.N(NUM_IRQ)) u_enc (
    .req   (pending & mask),
    .valid (enc_valid),
    .id    (enc_id)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      irq_q     <= '0;
      pending   <= '0;
      mask      <= '1;
      active_id <= '0;
      saved_epc <= '0;
    end else begin
      state   <= state_nxt;
      irq_q   <= irq_in;
      // A new edge on the line being acknowledged survives the clear.
      pending <= (pending & ~pend_clr) | irq_edge;
      if (mask_we) mask <= mask_wdata;
      if (state == IDLE && enc_valid) active_id <= enc_id;
      if (state == ENTER && redirect_ack) saved_epc <= epc_in;
    end
  end

  always_comb begin
    state_nxt    = state;
    pend_clr     = '0;
    redirect_req = 1'b0;
    flush        = 1'b0;
    redirect_pc  = '0;
    busy         = (state != IDLE);
    case (state)
      IDLE: begin
        if (enc_valid) state_nxt = ENTER;
      end
      ENTER: begin
        redirect_req = 1'b1;
        flush        = 1'b1;
        redirect_pc  = VECTOR_BASE + 32'(active_id) * VECTOR_STRIDE;
        if (redirect_ack) begin
          pend_clr[active_id] = 1'b1;
          state_nxt           = SERVICE;
        end
      end
      SERVICE: begin
        if (irq_return) state_nxt = RETURN;
      end
      RETURN: begin
        redirect_req = 1'b1;
        flush        = 1'b1;
        redirect_pc  = saved_epc;
        if (redirect_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
